// File: rtl/level_pkg.sv
// Shared types and helpers for the level sequencing logic.
package level_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FADE,
        LOAD,
        GAME_OVER
    } state_t;

    localparam int unsigned DEFAULT_LOAD_LEVEL = 0;
    localparam int unsigned FIELD_MAX_W        = 32;
    localparam int unsigned BUS_MAX_W          = 256;

    // Extracts field idx of width w from a zero-padded packed bus.
    function automatic logic [FIELD_MAX_W-1:0] get_field(
        input logic [BUS_MAX_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [FIELD_MAX_W-1:0] f;
        f = FIELD_MAX_W'(bus >> (idx * w));
        for (int unsigned b = 0; b < FIELD_MAX_W; b++) begin
            if (b >= w) f[b] = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/level_target_select.sv
// Combinational target level: unsigned max level over players with lives left.
module level_target_select
    import level_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned LEVEL_W     = 3,
    parameter int unsigned LIFE_W      = 2,
    parameter int unsigned LOAD_LEVEL  = DEFAULT_LOAD_LEVEL
) (
    input  logic [NUM_PLAYERS*LEVEL_W-1:0] player_level_num,
    input  logic [NUM_PLAYERS*LIFE_W-1:0]  player_life_counter,
    output logic [LEVEL_W-1:0]             target,
    output logic                           any_alive
);

    logic [BUS_MAX_W-1:0] level_bus;
    logic [BUS_MAX_W-1:0] life_bus;

    assign level_bus = BUS_MAX_W'(player_level_num);
    assign life_bus  = BUS_MAX_W'(player_life_counter);

    always_comb begin
        logic [LEVEL_W-1:0] best;
        logic [LEVEL_W-1:0] lvl;
        logic [LIFE_W-1:0]  life;
        best      = '0;
        any_alive = 1'b0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            lvl  = LEVEL_W'(get_field(level_bus, i, LEVEL_W));
            life = LIFE_W'(get_field(life_bus, i, LIFE_W));
            if (life != '0) begin
                any_alive = 1'b1;
                if (lvl > best) best = lvl;
            end
        end
        target = any_alive ? best : LEVEL_W'(LOAD_LEVEL);
    end

endmodule

// File: rtl/level_sequencer.sv
// Level commit sequencer: blanks the screen for a number of frames before
// loading a new target level, and parks on the loading room at game over.
module level_sequencer
    import level_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned LEVEL_W      = 3,
    parameter int unsigned LIFE_W       = 2,
    parameter int unsigned BLANK_FRAMES = 30,
    parameter int unsigned LOAD_LEVEL   = DEFAULT_LOAD_LEVEL
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_tick,
    input  logic [NUM_PLAYERS*LEVEL_W-1:0] player_level_num,
    input  logic [NUM_PLAYERS*LIFE_W-1:0]  player_life_counter,
    output logic [LEVEL_W-1:0]             level_num,
    output logic                           blank,
    output logic                           level_load,
    output logic                           game_over
);

    localparam int unsigned CNT_W = $clog2(BLANK_FRAMES + 1);

    state_t             state, state_n;
    logic [LEVEL_W-1:0] pend_level, pend_level_n;
    logic [LEVEL_W-1:0] level_n;
    logic [CNT_W-1:0]   frame_cnt, frame_cnt_n;
    logic [LEVEL_W-1:0] target;
    logic               any_alive;

    level_target_select #(
        .NUM_PLAYERS(NUM_PLAYERS),
        .LEVEL_W    (LEVEL_W),
        .LIFE_W     (LIFE_W),
        .LOAD_LEVEL (LOAD_LEVEL)
    ) u_target (
        .player_level_num   (player_level_num),
        .player_life_counter(player_life_counter),
        .target             (target),
        .any_alive          (any_alive)
    );

    always_comb begin
        state_n      = state;
        pend_level_n = pend_level;
        frame_cnt_n  = frame_cnt;
        level_n      = level_num;
        unique case (state)
            IDLE: begin
                if (!any_alive) begin
                    state_n = GAME_OVER;
                    level_n = LEVEL_W'(LOAD_LEVEL);
                end else if (target != level_num) begin
                    state_n      = FADE;
                    pend_level_n = target;
                    frame_cnt_n  = '0;
                end
            end
            FADE: begin
                // Death wins over a completing tick in the same cycle.
                if (!any_alive) begin
                    state_n = GAME_OVER;
                    level_n = LEVEL_W'(LOAD_LEVEL);
                end else if (frame_tick) begin
                    if (frame_cnt != CNT_W'(BLANK_FRAMES)) frame_cnt_n = frame_cnt + 1'b1;
                    if (frame_cnt == CNT_W'(BLANK_FRAMES - 1)) begin
                        state_n = LOAD;
                        level_n = pend_level;
                    end
                end
            end
            LOAD: begin
                state_n = IDLE;
            end
            GAME_OVER: begin
                if (any_alive) begin
                    if (target != LEVEL_W'(LOAD_LEVEL)) begin
                        state_n      = FADE;
                        pend_level_n = target;
                        frame_cnt_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            level_num  <= LEVEL_W'(LOAD_LEVEL);
            pend_level <= LEVEL_W'(LOAD_LEVEL);
            frame_cnt  <= '0;
            blank      <= 1'b0;
            level_load <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            level_num  <= level_n;
            pend_level <= pend_level_n;
            frame_cnt  <= frame_cnt_n;
            blank      <= (state_n != IDLE);
            level_load <= (state_n == LOAD);
            game_over  <= (state_n == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_level_sequencer.sv
// Randomized scoreboard bench for level_sequencer against a frame-count model.
module tb_level_sequencer;

    localparam int NP = 2;
    localparam int LW = 3;
    localparam int FW = 2;
    localparam int BF = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [LW-1:0] lvl [NP];
    logic [FW-1:0] life[NP];
    logic [NP*LW-1:0] lvl_bus;
    logic [NP*FW-1:0] life_bus;
    logic [LW-1:0] level_num;
    logic          blank, level_load, game_over;

    always #5 clk = ~clk;

    assign lvl_bus  = {lvl[1], lvl[0]};
    assign life_bus = {life[1], life[0]};

    level_sequencer #(
        .NUM_PLAYERS (NP),
        .LEVEL_W     (LW),
        .LIFE_W      (FW),
        .BLANK_FRAMES(BF),
        .LOAD_LEVEL  (0)
    ) dut (
        .Clk                (clk),
        .Reset              (rst),
        .frame_tick         (tick),
        .player_level_num   (lvl_bus),
        .player_life_counter(life_bus),
        .level_num          (level_num),
        .blank              (blank),
        .level_load         (level_load),
        .game_over          (game_over)
    );

    typedef struct {
        int lvl;
        bit blank;
        bit load;
        bit over;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference: a committed level, a pending level with frames still to wait,
    // a one-cycle load flag and a game-over flag.
    int cur = 0, pend = 0, frames_left = 0;
    bit fading = 0, loading = 0, dead = 0;

    task automatic model_step();
        int  tgt;
        bit  any;
        exp_t e;
        any = 0;
        tgt = 0;
        for (int i = 0; i < NP; i++) begin
            if (life[i] != 0) begin
                any = 1;
                if (int'(lvl[i]) > tgt) tgt = int'(lvl[i]);
            end
        end
        if (rst) begin
            cur = 0; pend = 0; fading = 0; loading = 0; dead = 0;
        end else if (dead) begin
            if (any) begin
                dead = 0;
                if (tgt != 0) begin
                    fading = 1; pend = tgt; frames_left = BF;
                end
            end
        end else if (loading) begin
            loading = 0;
        end else if (fading) begin
            if (!any) begin
                fading = 0; dead = 1; cur = 0;
            end else if (tick) begin
                frames_left--;
                if (frames_left == 0) begin
                    fading = 0; loading = 1; cur = pend;
                end
            end
        end else begin
            if (!any) begin
                dead = 1; cur = 0;
            end else if (tgt != cur) begin
                fading = 1; pend = tgt; frames_left = BF;
            end
        end
        e.lvl   = cur;
        e.blank = fading | loading | dead;
        e.load  = loading;
        e.over  = dead;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int l0, input int l1, input int f0, input int f1,
                         input bit tk, input bit r);
        lvl[0]  = LW'(l0);
        lvl[1]  = LW'(l1);
        life[0] = FW'(f0);
        life[1] = FW'(f1);
        tick    = tk;
        rst     = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("level_num",  int'(level_num),  e.lvl);
            check("blank",      int'(blank),      int'(e.blank));
            check("level_load", int'(level_load), int'(e.load));
            check("game_over",  int'(game_over),  int'(e.over));
        end
    end

    initial begin
        int l0, l1, f0, f1;
        lvl[0] = '0; lvl[1] = '0; life[0] = '0; life[1] = '0;
        tick = 1'b0;
        rst  = 1'b1;
        drive(0, 0, 3, 3, 0, 1);
        drive(0, 0, 3, 3, 1, 1);
        // Idle at level 0 with ticks arriving.
        for (int i = 0; i < 6; i++) drive(0, 0, 3, 3, i[0], 0);
        // Fade to max(1,2)=2, with a tick on the entry cycle.
        drive(1, 2, 3, 3, 1, 0);
        for (int i = 0; i < 12; i++) drive(1, 2, 3, 3, (i % 2 == 1), 0);
        // Dead player at level 3 is ignored.
        for (int i = 0; i < 12; i++) drive(3, 1, 0, 2, (i % 2 == 1), 0);
        // Target moves to 3 mid-fade toward 2.
        for (int i = 0; i < 4; i++) drive(0, 2, 1, 1, (i % 2 == 1), 0);
        for (int i = 0; i < 20; i++) drive(0, 3, 1, 1, (i % 2 == 1), 0);
        // Fade toward 1, then everyone dies mid-fade, then revive player 0 at 2.
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 1, (i % 2 == 1), 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 14; i++) drive(2, 1, 2, 0, (i % 2 == 1), 0);
        // Reset on the third tick of a fade.
        drive(5, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) drive(5, 0, 1, 0, 1, 0);
        drive(5, 0, 1, 0, 1, 1);
        drive(0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 1, 1, 0);
        // Revive from game over at the loading level.
        drive(4, 4, 0, 0, 0, 0);
        drive(4, 4, 0, 0, 1, 0);
        drive(0, 6, 2, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 6, 2, 0, 0, 0);

        l0 = 0; l1 = 0; f0 = 3; f1 = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) l0 = $urandom_range(0, 7);
            if ($urandom_range(0, 19) == 0) l1 = $urandom_range(0, 7);
            if ($urandom_range(0, 39) == 0) f0 = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3);
            if ($urandom_range(0, 39) == 0) f1 = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3);
            drive(l0, l1, f0, f1, ($urandom_range(0, 2) == 0), ($urandom_range(0, 299) == 0));
        end
        drive(l0, l1, f0, f1, 0, 0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
